// File: rtl/otp_key_sequencer.sv
// otp_key_sequencer: one-time-pad key store and XOR sequencer.
// Each key byte is consumed exactly once and zeroized after use.
module otp_key_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        clear,
  input  logic        key_load,
  input  logic        key_valid,
  input  logic [7:0]  key_byte,
  input  logic        key_done,
  input  logic        data_valid,
  input  logic [7:0]  data_in,
  output logic        data_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic [1:0]  state,
  output logic [AW:0] keys_left,
  output logic        reuse_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    RUN       = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [AW-1:0] rd_ptr, rd_ptr_d;
  logic [AW:0]   key_len, key_len_d;
  logic          err_d;
  logic          wr_en;
  logic          rd_en;
  logic [7:0]    key_mem [DEPTH];

  // ready is gated by ena/clear so upstream never loses a byte
  assign data_ready = ena & ~clear & (state_q == RUN);
  assign state      = state_q;
  assign keys_left  = (state_q == RUN) ? key_len - {1'b0, rd_ptr} : '0;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr;
    rd_ptr_d  = rd_ptr;
    key_len_d = key_len;
    err_d     = reuse_err;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_load) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end
      end
      LOAD: begin
        if (key_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr + 1'b1;
          if (wr_ptr == LAST) begin
            state_d   = RUN;
            key_len_d = FULL;
            rd_ptr_d  = '0;
          end else if (key_done) begin
            state_d   = RUN;
            key_len_d = {1'b0, wr_ptr} + 1'b1;
            rd_ptr_d  = '0;
          end
        end else if (key_done) begin
          if (wr_ptr != '0) begin
            state_d   = RUN;
            key_len_d = {1'b0, wr_ptr};
            rd_ptr_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      RUN: begin
        if (data_valid && data_ready) begin
          rd_en    = 1'b1;
          rd_ptr_d = rd_ptr + 1'b1;
          if ({1'b0, rd_ptr} == key_len - 1'b1) begin
            state_d = EXHAUSTED;
          end
        end
      end
      EXHAUSTED: begin
        if (data_valid) err_d = 1'b1;
        if (key_load) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          err_d    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_len   <= '0;
      reuse_err <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= '0;
      for (int i = 0; i < DEPTH; i++) key_mem[i] <= '0;
    end else if (clear) begin
      state_q   <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_len   <= '0;
      reuse_err <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) key_mem[i] <= '0;
    end else if (!ena) begin
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr    <= wr_ptr_d;
      rd_ptr    <= rd_ptr_d;
      key_len   <= key_len_d;
      reuse_err <= err_d;
      out_valid <= rd_en;
      if (rd_en) begin
        out_byte        <= data_in ^ key_mem[rd_ptr];
        key_mem[rd_ptr] <= '0;
      end
      if (wr_en) key_mem[wr_ptr] <= key_byte;
    end
  end

endmodule

// File: tb/tb_otp_key_sequencer.sv
// tb_otp_key_sequencer: directed stimulus with a queue-based
// scoreboard for out_byte plus direct status checks.
module tb_otp_key_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic       key_load;
  logic       key_valid;
  logic [7:0] key_byte;
  logic       key_done;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic       out_valid;
  logic [7:0] out_byte;
  logic [1:0] state;
  logic [4:0] keys_left;
  logic       reuse_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];

  otp_key_sequencer #(.DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .clear      (clear),
    .key_load   (key_load),
    .key_valid  (key_valid),
    .key_byte   (key_byte),
    .key_done   (key_done),
    .data_valid (data_valid),
    .data_in    (data_in),
    .data_ready (data_ready),
    .out_valid  (out_valid),
    .out_byte   (out_byte),
    .state      (state),
    .keys_left  (keys_left),
    .reuse_err  (reuse_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: every output pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h expected none", out_byte);
      end else begin
        chk("out_byte", {24'd0, out_byte}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k3 [3];
    logic [7:0] e3 [3];
    k3 = '{8'hAA, 8'h55, 8'h0F};
    e3 = '{8'hAA, 8'h55, 8'h0F};
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0;
    key_load = 1'b0; key_valid = 1'b0; key_byte = '0;
    key_done = 1'b0; data_valid = 1'b0; data_in = '0;
    #12;
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_keys_left", {27'd0, keys_left}, 0);
    chk("rst_ready", {31'd0, data_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_byte", {24'd0, out_byte}, 0);
    chk("rst_reuse_err", {31'd0, reuse_err}, 0);
    rst_n = 1'b1;
    step();

    // full 16-byte key, stream of 0xFF
    key_load = 1'b1; step(); key_load = 1'b0;
    chk("t1_load_state", {30'd0, state}, 1);
    for (int i = 0; i < 16; i++) begin
      key_valid = 1'b1; key_byte = 8'(i + 1);
      step();
    end
    key_valid = 1'b0;
    chk("t1_run_state", {30'd0, state}, 2);
    chk("t1_keys_full", {27'd0, keys_left}, 16);
    for (int i = 0; i < 16; i++) begin
      data_valid = 1'b1; data_in = 8'hFF;
      chk("t1_keys_left", {27'd0, keys_left}, 32'(16 - i));
      chk("t1_ready", {31'd0, data_ready}, 1);
      exp_q.push_back(8'hFF ^ 8'(i + 1));
      step();
    end
    data_valid = 1'b0;
    chk("t1_exh_state", {30'd0, state}, 3);
    chk("t1_exh_keys", {27'd0, keys_left}, 0);

    // short key with key_done on the last write, then reuse attempt
    key_load = 1'b1; step(); key_load = 1'b0;
    chk("t2_load_state", {30'd0, state}, 1);
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key_byte = k3[i];
      key_done = (i == 2);
      step();
    end
    key_valid = 1'b0; key_done = 1'b0;
    chk("t2_run_state", {30'd0, state}, 2);
    chk("t2_keys_len", {27'd0, keys_left}, 3);
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1; data_in = 8'h00;
      exp_q.push_back(e3[i]);
      step();
    end
    chk("t2_exh_state", {30'd0, state}, 3);
    chk("t2_exh_ready", {31'd0, data_ready}, 0);
    step();
    data_valid = 1'b0;
    chk("t2_reuse_err", {31'd0, reuse_err}, 1);
    step();
    chk("t2_reuse_sticky", {31'd0, reuse_err}, 1);

    // empty key returns to IDLE; data ignored
    key_load = 1'b1; step(); key_load = 1'b0;
    chk("t3_reuse_clr", {31'd0, reuse_err}, 0);
    key_done = 1'b1; step(); key_done = 1'b0;
    chk("t3_idle_state", {30'd0, state}, 0);
    data_valid = 1'b1; data_in = 8'h77;
    chk("t3_ready", {31'd0, data_ready}, 0);
    step(); step();
    data_valid = 1'b0;
    chk("t3_out_valid", {31'd0, out_valid}, 0);

    // clear after 2 of 4 bytes
    key_load = 1'b1; step(); key_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_byte = 8'hA0 + 8'(i);
      key_done = (i == 3);
      step();
    end
    key_valid = 1'b0; key_done = 1'b0;
    chk("t4_keys_len", {27'd0, keys_left}, 4);
    data_valid = 1'b1; data_in = 8'h00;
    exp_q.push_back(8'hA0); step();
    exp_q.push_back(8'hA1); step();
    data_valid = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    chk("t4_clr_state", {30'd0, state}, 0);
    chk("t4_clr_keys", {27'd0, keys_left}, 0);
    chk("t4_clr_mem2", {24'd0, dut.key_mem[2]}, 0);
    chk("t4_clr_mem3", {24'd0, dut.key_mem[3]}, 0);

    // reload 0x11 x4, stream with an ena=0 gap after 2 bytes
    key_load = 1'b1; step(); key_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_byte = 8'h11;
      key_done = (i == 3);
      step();
    end
    key_valid = 1'b0; key_done = 1'b0;
    data_valid = 1'b1;
    data_in = 8'h01; exp_q.push_back(8'h10); step();
    data_in = 8'h02; exp_q.push_back(8'h13); step();
    ena = 1'b0; data_in = 8'h03;
    for (int i = 0; i < 5; i++) step();
    chk("t5_freeze_keys", {27'd0, keys_left}, 2);
    chk("t5_freeze_state", {30'd0, state}, 2);
    chk("t5_freeze_ov", {31'd0, out_valid}, 0);
    ena = 1'b1;
    data_in = 8'h03; exp_q.push_back(8'h12); step();
    data_in = 8'h04; exp_q.push_back(8'h15); step();
    data_valid = 1'b0;
    chk("t5_exh_state", {30'd0, state}, 3);

    // async reset during LOAD
    key_load = 1'b1; step(); key_load = 1'b0;
    key_valid = 1'b1; key_byte = 8'h5A; step();
    key_byte = 8'h5B; step();
    key_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_state", {30'd0, state}, 0);
    chk("t6_out_byte", {24'd0, out_byte}, 0);
    chk("t6_out_valid", {31'd0, out_valid}, 0);
    chk("t6_keys", {27'd0, keys_left}, 0);
    chk("t6_mem0", {24'd0, dut.key_mem[0]}, 0);
    chk("t6_mem1", {24'd0, dut.key_mem[1]}, 0);
    #2 rst_n = 1'b1;
    step();
    chk("t6_post_state", {30'd0, state}, 0);
    chk("t6_post_mem0", {24'd0, dut.key_mem[0]}, 0);

    // one-byte key after reset still works
    key_load = 1'b1; step(); key_load = 1'b0;
    key_valid = 1'b1; key_byte = 8'h3C; key_done = 1'b1; step();
    key_valid = 1'b0; key_done = 1'b0;
    chk("t7_keys_len", {27'd0, keys_left}, 1);
    data_valid = 1'b1; data_in = 8'hC3;
    exp_q.push_back(8'hFF); step();
    data_valid = 1'b0;
    step(); step();
    chk("t7_exh_state", {30'd0, state}, 3);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
